// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-stage types: PC type, sequential step and next-PC source tags.
// Also consumed by the BTB/gshare update logic.
package fetch_pkg;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef logic [31:0] pc_t;

  typedef enum logic [2:0] {
    SRC_RESET   = 3'd0,
    SRC_MISPRED = 3'd1,
    SRC_JUMP    = 3'd2,
    SRC_HOLD    = 3'd3,
    SRC_BTB     = 3'd4,
    SRC_SEQ     = 3'd5
  } next_src_t;

  // Byte PC to instruction-memory word address.
  function automatic pc_t word_addr(input pc_t pc);
    return {2'b00, pc[31:2]};
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch bus between the PC generator (master) and imem/decode/BTB/branch unit (slave).
interface fetch_pc_gen_if #(
  parameter int unsigned WIDTH = 31
);
  import fetch_pkg::*;

  logic             stall;
  logic             mispredict;
  logic [WIDTH:0]   correctPC;
  logic             jumpValid;
  logic [WIDTH:0]   jumpPC;
  logic             btbHit;
  logic [WIDTH:0]   btbTarget;
  logic [WIDTH:0]   rAddress;
  logic [WIDTH:0]   instr;
  logic             fetchValid;
  logic [WIDTH:0]   fetchPC;
  logic [WIDTH:0]   fetchSeqPC;
  logic [WIDTH:0]   fetchInstr;
  logic             predTaken;

  modport master (
    input  stall, mispredict, correctPC, jumpValid, jumpPC, btbHit, btbTarget, instr,
    output rAddress, fetchValid, fetchPC, fetchSeqPC, fetchInstr, predTaken
  );

  modport slave (
    output stall, mispredict, correctPC, jumpValid, jumpPC, btbHit, btbTarget, instr,
    input  rAddress, fetchValid, fetchPC, fetchSeqPC, fetchInstr, predTaken
  );

endinterface

// File: rtl/fetch_pc_gen_next_pc.sv
// Fixed-priority next-PC select: reset, mispredict, decode jump, hold, BTB, sequential.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic      reset_n_i,
  input  logic      stall_i,
  input  logic      mispredict_i,
  input  pc_t       correct_pc_i,
  input  logic      jump_valid_i,
  input  pc_t       jump_pc_i,
  input  logic      btb_hit_i,
  input  pc_t       btb_target_i,
  input  logic      valid_q_i,
  input  pc_t       pc_q_i,
  output pc_t       next_pc_o,
  output next_src_t next_src_o
);

  // Priority chain; jumps wait for decode to advance, holds re-read the same word.
  always_comb begin
    next_pc_o  = pc_q_i + PC_STEP;
    next_src_o = SRC_SEQ;
    if (!reset_n_i) begin
      next_pc_o  = RESET_PC;
      next_src_o = SRC_RESET;
    end else if (mispredict_i) begin
      next_pc_o  = correct_pc_i;
      next_src_o = SRC_MISPRED;
    end else if (jump_valid_i && !stall_i) begin
      next_pc_o  = jump_pc_i;
      next_src_o = SRC_JUMP;
    end else if (stall_i || !valid_q_i) begin
      next_pc_o  = pc_q_i;
      next_src_o = SRC_HOLD;
    end else if (btb_hit_i) begin
      next_pc_o  = btb_target_i;
      next_src_o = SRC_BTB;
    end else begin
      next_pc_o  = pc_q_i + PC_STEP;
      next_src_o = SRC_SEQ;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: owns the PC/valid registers, wrong-path squash and
// imem word-address formatting around the fetch_next_pc priority mux.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           resetN,
  fetch_pc_gen_if.master bus
);

  pc_t       pc_q;
  pc_t       pc_d;
  logic      valid_q;
  next_src_t next_src_s;
  logic      fetch_valid_s;

  fetch_next_pc #(
    .RESET_PC (RESET_PC)
  ) u_next_pc (
    .reset_n_i    (resetN),
    .stall_i      (bus.stall),
    .mispredict_i (bus.mispredict),
    .correct_pc_i (bus.correctPC),
    .jump_valid_i (bus.jumpValid),
    .jump_pc_i    (bus.jumpPC),
    .btb_hit_i    (bus.btbHit),
    .btb_target_i (bus.btbTarget),
    .valid_q_i    (valid_q),
    .pc_q_i       (pc_q),
    .next_pc_o    (pc_d),
    .next_src_o   (next_src_s)
  );

  // PC of the word now on instr, and whether it is a real post-reset fetch.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
    end
  end

  // A redirect this cycle means the word on instr is wrong-path.
  always_comb begin
    fetch_valid_s = valid_q & ~bus.mispredict & ~(bus.jumpValid & ~bus.stall);
  end

  assign bus.rAddress   = word_addr(pc_d);
  assign bus.fetchValid = fetch_valid_s;
  assign bus.fetchPC    = pc_q;
  assign bus.fetchSeqPC = pc_q + PC_STEP;
  assign bus.fetchInstr = bus.instr;
  assign bus.predTaken  = fetch_valid_s & (next_src_s == SRC_BTB);

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed plus randomized check of fetch_pc_gen against a cycle-level reference model.
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  logic clk;
  logic resetN;
  fetch_pc_gen_if #(.WIDTH(31)) bus ();

  fetch_pc_gen #(.RESET_PC(32'h0000_0000)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pc_t mem_word(input pc_t waddr);
    return (waddr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) bus.instr <= mem_word(bus.rAddress);

  int   n_vec = 0;
  int   n_bad = 0;
  pc_t  m_pc;
  bit   m_valid;
  bit   m_known = 1'b0;
  bit   m_mem_ok = 1'b0;

  task automatic chk(input string tag, input pc_t obs, input pc_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit st, input bit mp, input pc_t cpc,
                      input bit jv, input pc_t jpc, input bit bh, input pc_t bt);
    pc_t nxt;
    bit  ev;
    bit  ep;
    resetN         = rn;
    bus.stall      = st;
    bus.mispredict = mp;
    bus.correctPC  = cpc;
    bus.jumpValid  = jv;
    bus.jumpPC     = jpc;
    bus.btbHit     = bh;
    bus.btbTarget  = bt;
    #1;
    if (!rn)                   nxt = 32'h0000_0000;
    else if (mp)               nxt = cpc;
    else if (jv && !st)        nxt = jpc;
    else if (st || !m_valid)   nxt = m_pc;
    else if (bh)               nxt = bt;
    else                       nxt = m_pc + 32'd4;
    ev = m_valid && !mp && !(jv && !st);
    ep = ev && bh && !st;
    if (m_known) begin
      chk("rAddress", bus.rAddress, nxt / 32'd4);
      chk("fetchValid", {31'd0, bus.fetchValid}, {31'd0, ev});
      chk("predTaken", {31'd0, bus.predTaken}, {31'd0, ep});
      chk("fetchPC", bus.fetchPC, m_pc);
      chk("fetchSeqPC", bus.fetchSeqPC, m_pc + 32'd4);
      if (m_mem_ok) chk("fetchInstr", bus.fetchInstr, mem_word(m_pc / 32'd4));
    end
    @(posedge clk);
    if (m_known) m_mem_ok = 1'b1;
    m_pc    = nxt;
    m_valid = rn;
    m_known = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    bit  rn, st, mp, jv, bh;
    pc_t cpc, jpc, bt;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle();                                                    // bubble, rAddress 0
    idle();                                                    // fetchPC 0x00
    idle();                                                    // fetchPC 0x04
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h40);  // 0x08 predicted -> 0x40
    idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 1'b0, 32'd0);  // jump squash
    idle();
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h100); // stall beats btb
    step(1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h300, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 32'h300, 1'b0, 32'd0); // stalled jump ignored
    idle();
    step(1'b1, 1'b0, 1'b1, 32'hC0, 1'b1, 32'h80, 1'b0, 32'd0); // mispredict wins
    idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
    idle();                                                    // 0xFFFFFFFC -> wraps
    idle();
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_1236, 1'b0, 32'd0); // unaligned target
    idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);   // reset mid-stream
    idle();
    idle();
    for (int i = 0; i < 3000; i++) begin
      rn  = ($urandom_range(0, 99) != 0);
      st  = ($urandom_range(0, 3) == 0);
      mp  = ($urandom_range(0, 11) == 0);
      jv  = ($urandom_range(0, 9) == 0);
      bh  = rn && ($urandom_range(0, 4) == 0);
      cpc = $urandom() & 32'hFFFF_FFFC;
      jpc = $urandom();
      bt  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'h0000_FFFC);
      step(rn, st, mp, cpc, jv, jpc, bh, bt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage address initiator that drives the synchronous-read instruction memory and presents fetched instructions to decode. Each cycle it selects the next fetch PC by fixed priority: mispredict correction, decode jump target, BTB predicted target, then sequential PC. It issues the selected PC as a word address and tracks the one-cycle read latency. It squashes wrong-path fetches and holds the address under decode backpressure.

## Interface
- WIDTH, 31, MSB index of PC and instruction buses (32-bit).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- resetN  in  1  synchronous, active-low reset.
- stall  in  1  decode cannot accept the current fetch output.
- mispredict  in  1  branch resolution redirect.
- correctPC  in  WIDTH+1  redirect target for mispredict.
- jumpValid  in  1  decode found a jump, or found that a BTB-predicted instruction is not a branch.
- jumpPC  in  WIDTH+1  decode redirect target (jump target or fetchSeqPC).
- btbHit  in  1  BTB predicts taken for fetchPC.
- btbTarget  in  WIDTH+1  predicted target for fetchPC.
- rAddress  out  WIDTH+1  word address to instruction memory: {2'b00, nextPC[WIDTH:2]}; combinational.
- instr  in  WIDTH+1  instruction memory read data; valid one edge after rAddress.
- fetchValid  out  1  fetchInstr/fetchPC are a live, non-squashed fetch.
- fetchPC  out  WIDTH+1  PC of fetchInstr.
- fetchSeqPC  out  WIDTH+1  fetchPC + 4, pipelined to decode for non-branch recovery.
- fetchInstr  out  WIDTH+1  instr passed through.
- predTaken  out  1  btbHit was used to select the next PC for this fetch.

## Operation
- State: pcReg holds the PC whose data is currently on instr. validReg is 0 from reset until the first post-reset fetch lands. predReg records predTaken.
- nextPC priority:
  1. resetN=0 gives RESET_PC.
  2. mispredict gives correctPC. It is honoured even while stall=1.
  3. jumpValid & ~stall gives jumpPC. jumpValid is ignored while stall=1, and decode re-asserts it when it advances.
  4. stall | ~validReg gives pcReg. The same word is re-read, so instr stays stable.
  5. btbHit gives btbTarget.
  6. Otherwise pcReg+4.
- Arithmetic: the +4 wraps modulo 2^32 with no carry-out. The low two PC bits are dropped only in rAddress. fetchPC carries the full value.
- Every edge updates pcReg <= nextPC and validReg <= resetN. The imem captures rAddress on the same edge.
- fetchValid = validReg & ~mispredict & ~(jumpValid & ~stall). The wrong-path word on instr in a redirect cycle is never presented as valid.
- predTaken = fetchValid & btbHit & ~stall, meaning this fetch's successor was the BTB target.
- On reset, pcReg=RESET_PC and validReg=0, so fetchValid=0. rAddress=RESET_PC>>2. predTaken=0.
- Reset mid-operation discards any in-flight fetch. Redirect inputs are ignored while resetN=0.
- Simultaneous mispredict and jumpValid: mispredict wins and fetchValid=0.
- btbHit together with stall: the hold wins and the prediction is re-evaluated next cycle.

## Timing
- Fetch latency: a PC selected in cycle N appears on fetchPC/fetchInstr with fetchValid in cycle N+1.
- After resetN rises at edge E0, fetchValid=1 for RESET_PC from the cycle after edge E1.
- Redirect penalty: one squashed cycle. The target is live the cycle after the redirect is asserted.
- Under stall, fetchPC/fetchInstr/fetchValid are held stable every cycle until stall drops. The exception is a mispredict, which kills the output that same cycle.
- Throughput: one instruction per cycle when stall=0 and no redirect.

## Structure
- Shared package fetch_pkg:
  - PC_STEP=4.
  - Typedef pc_t = logic[31:0].
  - Enum next_src_t {SRC_RESET, SRC_MISPRED, SRC_JUMP, SRC_HOLD, SRC_BTB, SRC_SEQ}.
  - Also used by BTB/gshare update logic.
- Sub-module fetch_next_pc: combinational priority mux that produces nextPC and next_src_t. fetch_pc_gen owns all registers, the squash logic and the rAddress formatting.

## Test plan
- Reset release with RESET_PC=0, no redirects:
  - fetchValid=0 for one cycle, then fetchPC=0x00, 0x04, 0x08 on consecutive cycles.
  - rAddress=0x00, 0x01, 0x02, 0x03; fetchSeqPC=fetchPC+4.
- btbHit=1, btbTarget=0x40 while fetchPC=0x08 → predTaken=1, next fetchPC=0x40, no bubble.
- jumpValid=1, jumpPC=0x80 while fetchPC=0x0C → fetchValid=0 that cycle, next cycle fetchPC=0x80 valid.
- stall held 3 cycles at fetchPC=0x10 → outputs frozen at 0x10 and rAddress=0x04 throughout. A mispredict (correctPC=0x20) in cycle 2 kills fetchValid immediately, and fetchPC=0x20 follows.
- mispredict (0xC0) and jumpValid (0x80) in the same cycle → next fetchPC=0xC0.
- pcReg=0xFFFF_FFFC sequential → next fetchPC=0x0000_0000. resetN low mid-stream → fetchValid=0 next cycle and fetch restarts at RESET_PC.
